fifo: RTL and testbench

Synchronous first-word-fall-through FIFO with a parameterizable width and power-of-two depth. It buffers bytes between a host interface and serial shifters, such as the TX and RX paths of the SPI master transceiver. It provides a head-of-queue output and three occupancy flags: present, half-full and full. One clock domain; no internal clock crossing.

---
 rtl/fifo.sv | 94 +++++++++
 tb/tb_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// fifo -- synchronous first-word-fall-through FIFO.
//
// Buffers WIDTH-bit words between a host interface and a serial shifter,
// for example the TX and RX paths of an SPI master. The oldest word is always
// visible on dataOut, and read only discards it. All state is in one clock
// domain.
//
// Parameters:
//   WIDTH       word width in bits (>= 1)
//   LOG2_DEPTH  log2 of the number of storage words (>= 1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   write        push strobe, level-sampled on every edge
//   read         pop strobe, level-sampled on every edge
//   dataIn       word to push
//   dataOut      head (oldest) word, driven from storage only
//   dataPresent  count != 0
//   halfFull     count >= DEPTH/2
//   full         count == DEPTH
//
// Handshake: write acts as "valid" and the inverse of full acts as "ready".
// A push takes effect on an edge where write=1 and either the FIFO is not
// full or a pop happens on the same edge. A pop takes effect on an edge where
// read=1 and dataPresent=1. Strobes that do not qualify are dropped silently.
// No status output has a combinational path from write, read or dataIn.
module fifo #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataPresent,
  output logic             halfFull,
  output logic             full
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0] HALF_COUNT = (LOG2_DEPTH + 1)'(DEPTH / 2);

  logic [WIDTH-1:0]      storage [DEPTH];
  // The power-up values match the reset values.
  logic [LOG2_DEPTH-1:0] wrPtr = '0;
  logic [LOG2_DEPTH-1:0] rdPtr = '0;
  logic [LOG2_DEPTH:0]   count = '0;

  logic isEmpty;
  logic isFull;
  logic pushOk;
  logic popOk;

  assign isEmpty = (count == '0);
  assign isFull  = (count == FULL_COUNT);

  // When the FIFO is full, a simultaneous pop frees the slot that the push
  // then fills. When it is empty, the pop has nothing to remove, so only the
  // push counts.
  assign pushOk = write && (!isFull || read);
  assign popOk  = read && !isEmpty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not cleared on reset. A push on a reset edge is suppressed,
  // and the pointers are zeroed on that edge anyway.
  always_ff @(posedge clk) begin
    if (rst && pushOk) storage[wrPtr] <= dataIn;
  end

  assign dataOut     = storage[rdPtr];
  assign dataPresent = !isEmpty;
  assign halfFull    = (count >= HALF_COUNT);
  assign full        = isFull;

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr  = 1'b0;
  logic         rd  = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dataOut;
  logic         dataPresent;
  logic         halfFull;
  logic         full;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: an ordered list of the words held, oldest first.
  logic [W-1:0] exp_q[$];

  fifo #(.WIDTH(W), .LOG2_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .write(wr), .read(rd), .dataIn(din),
    .dataOut(dataOut), .dataPresent(dataPresent), .halfFull(halfFull),
    .full(full)
  );

  always #5 clk = ~clk;

  // Drives one cycle of strobes, applies the acceptance rules to the model at
  // the edge, and leaves the outputs settled 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    bit wasEmpty, wasFull, doPush, doPop;
    wr = w; rd = r; din = d;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
    end else begin
      wasEmpty = (exp_q.size() == 0);
      wasFull  = (exp_q.size() == DEPTH);
      doPop    = r && !wasEmpty;
      doPush   = w && (!wasFull || r);
      if (doPop)  void'(exp_q.pop_front());
      if (doPush) exp_q.push_back(d);
    end
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, '0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    nCompared++; if (dataPresent !== 1'b0) begin nMismatched++; $display("FAIL reset_present: got %b want 0", dataPresent); end
    nCompared++; if (halfFull !== 1'b0) begin nMismatched++; $display("FAIL reset_half: got %b want 0", halfFull); end
    nCompared++; if (full !== 1'b0) begin nMismatched++; $display("FAIL reset_full: got %b want 0", full); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, '0);
      nCompared++;
      if (dataPresent !== 1'b0 || halfFull !== 1'b0 || full !== 1'b0) begin
        nMismatched++;
        $display("FAIL underflow_flags: got p=%b h=%b f=%b want 0 0 0", dataPresent, halfFull, full);
      end
    end
    step(1'b1, 1'b0, 8'h5A);
    nCompared++; if (dataOut !== 8'h5A) begin nMismatched++; $display("FAIL after_underflow_data: got %h want 5a", dataOut); end
    step(1'b0, 1'b1, '0);
    nCompared++; if (dataPresent !== 1'b0) begin nMismatched++; $display("FAIL after_underflow_empty: got %b want 0", dataPresent); end
  endtask

  task automatic test_fall_through();
    step(1'b1, 1'b0, 8'hA5);
    nCompared++; if (dataPresent !== 1'b1) begin nMismatched++; $display("FAIL ft_present: got %b want 1", dataPresent); end
    nCompared++; if (dataOut !== 8'hA5) begin nMismatched++; $display("FAIL ft_data: got %h want a5", dataOut); end
    step(1'b0, 1'b0, '0);
    nCompared++; if (dataOut !== 8'hA5) begin nMismatched++; $display("FAIL ft_hold: got %h want a5", dataOut); end
    step(1'b0, 1'b1, '0);
    nCompared++; if (dataPresent !== 1'b0) begin nMismatched++; $display("FAIL ft_pop: got %b want 0", dataPresent); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, W'(i));
      nCompared++;
      if (halfFull !== (i >= 7)) begin nMismatched++; $display("FAIL fill_half[%0d]: got %b want %b", i, halfFull, (i >= 7)); end
      nCompared++;
      if (full !== (i == DEPTH - 1)) begin nMismatched++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == DEPTH - 1)); end
    end
    step(1'b1, 1'b0, 8'hFF);
    nCompared++; if (full !== 1'b1) begin nMismatched++; $display("FAIL overflow_full: got %b want 1", full); end
    nCompared++; if (dataOut !== 8'h00) begin nMismatched++; $display("FAIL overflow_head: got %h want 00", dataOut); end
    for (int i = 0; i < DEPTH; i++) begin
      nCompared++;
      if (dataOut !== W'(i)) begin nMismatched++; $display("FAIL drain_order[%0d]: got %h want %h", i, dataOut, W'(i)); end
      step(1'b0, 1'b1, '0);
    end
    nCompared++; if (dataPresent !== 1'b0) begin nMismatched++; $display("FAIL drain_empty: got %b want 0", dataPresent); end
  endtask

  task automatic test_wrap();
    int nextIn  = 8'h20;
    int nextOut = 8'h20;
    for (int round = 0; round < 10; round++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b1, 1'b0, W'(nextIn));
        nextIn++;
      end
      for (int i = 0; i < 5; i++) begin
        nCompared++;
        if (dataOut !== W'(nextOut)) begin nMismatched++; $display("FAIL wrap_order[%0d]: got %h want %h", round, dataOut, W'(nextOut)); end
        nextOut++;
        step(1'b0, 1'b1, '0);
      end
    end
    nCompared++; if (dataPresent !== 1'b0) begin nMismatched++; $display("FAIL wrap_empty: got %b want 0", dataPresent); end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b1, 8'h3C);
    nCompared++; if (dataPresent !== 1'b1) begin nMismatched++; $display("FAIL simul_empty_present: got %b want 1", dataPresent); end
    nCompared++; if (dataOut !== 8'h3C) begin nMismatched++; $display("FAIL simul_empty_data: got %h want 3c", dataOut); end
    step(1'b0, 1'b1, '0);
    nCompared++; if (dataPresent !== 1'b0) begin nMismatched++; $display("FAIL simul_empty_count1: got %b want 0", dataPresent); end
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b1, 8'h77);
    nCompared++; if (full !== 1'b1) begin nMismatched++; $display("FAIL simul_full_flag: got %b want 1", full); end
    nCompared++; if (dataOut !== 8'h01) begin nMismatched++; $display("FAIL simul_full_head: got %h want 01", dataOut); end
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, '0);
    nCompared++; if (dataOut !== 8'h77) begin nMismatched++; $display("FAIL simul_full_last: got %h want 77", dataOut); end
    step(1'b0, 1'b1, '0);
    nCompared++; if (dataPresent !== 1'b0) begin nMismatched++; $display("FAIL simul_full_drain: got %b want 0", dataPresent); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, W'(8'h40 + i));
    rst = 1'b0;
    step(1'b1, 1'b0, 8'hEE);
    rst = 1'b1;
    nCompared++;
    if (dataPresent !== 1'b0 || halfFull !== 1'b0 || full !== 1'b0) begin
      nMismatched++;
      $display("FAIL midreset_flags: got p=%b h=%b f=%b want 0 0 0", dataPresent, halfFull, full);
    end
    step(1'b1, 1'b0, 8'h99);
    nCompared++; if (dataOut !== 8'h99) begin nMismatched++; $display("FAIL midreset_next: got %h want 99", dataOut); end
    step(1'b0, 1'b1, '0);
    nCompared++; if (dataPresent !== 1'b0) begin nMismatched++; $display("FAIL midreset_single: got %b want 0", dataPresent); end
  endtask

  task automatic test_random();
    bit w, r;
    for (int i = 0; i < 3000; i++) begin
      // Phases bias toward filling or draining so both boundaries are hit.
      if ((i / 200) % 2 == 0) begin
        w = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 3);
      end else begin
        w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 7);
      end
      rst = ($urandom_range(0, 499) != 0);
      step(w, r, W'($urandom));
      rst = 1'b1;
      nCompared++;
      if (dataPresent !== (exp_q.size() != 0) || halfFull !== (exp_q.size() >= DEPTH / 2) ||
          full !== (exp_q.size() == DEPTH)) begin
        nMismatched++;
        $display("FAIL rand_flags[%0d]: got p=%b h=%b f=%b for size %0d", i, dataPresent, halfFull, full, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        nCompared++;
        if (dataOut !== exp_q[0]) begin nMismatched++; $display("FAIL rand_head[%0d]: got %h want %h", i, dataOut, exp_q[0]); end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fall_through();
    test_fill();
    test_wrap();
    test_simultaneous();
    do_reset();
    test_mid_reset();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
